// File: rtl/uart_led_pkg.sv
// Shared constants and FSM state type for the UART LED PWM controller.
package uart_led_pkg;

    localparam logic [7:0] CMD_SET_ONE = 8'h4C;  // 'L' channel duty
    localparam logic [7:0] CMD_SET_ALL = 8'h41;  // 'A' duty

    typedef enum logic [1:0] {
        IDLE,
        GET_CH,
        GET_DUTY,
        GET_ALL
    } state_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: duty register, compare against the shared counter, registered pin.
module pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                enable,
    output logic                led
);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    // Next duty and pin value; all-ones duty is forced on so it never drops a cycle.
    always_comb begin
        duty_d = wr_en ? wr_duty : duty_q;
        led_d  = enable && ((duty_q == '1) || (pwm_cnt < duty_q));
    end

    // Duty and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/uart_led_pwm.sv
// UART command parser driving NUM_LEDS PWM channels, with button blanking and
// an inter-byte timeout that discards truncated commands.
module uart_led_pwm
    import uart_led_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 1,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic                clk_rx,
    input  logic                rst_clk_rx,
    input  logic                btn_clk_rx,
    input  logic [7:0]          rx_data,
    input  logic                rx_data_rdy,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                cmd_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_e              state_q, state_d;
    logic [7:0]          ch_q, ch_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                err_q, err_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                btn_q, btn_d;
    logic                enable_q, enable_d;
    logic                wr_one, wr_all, ch_ok;

    assign ch_ok = {1'b0, ch_q} < 9'(NUM_LEDS);

    // Command parser and timeout; a byte arriving on the expiry cycle takes priority.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        wr_one  = 1'b0;
        wr_all  = 1'b0;
        if (rx_data_rdy) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (rx_data == CMD_SET_ONE)      state_d = GET_CH;
                    else if (rx_data == CMD_SET_ALL) state_d = GET_ALL;
                end
                GET_CH: begin
                    ch_d    = rx_data;
                    state_d = GET_DUTY;
                end
                GET_DUTY: begin
                    if (ch_ok) wr_one = 1'b1;
                    else       err_d  = 1'b1;
                    state_d = IDLE;
                end
                GET_ALL: begin
                    wr_all  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Shared PWM timebase and button-driven blanking toggle.
    always_comb begin
        pre_d = pre_q + PW'(1);
        cnt_d = cnt_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            cnt_d = cnt_q + PWM_BITS'(1);
        end
        btn_d    = btn_clk_rx;
        enable_d = enable_q ^ (btn_clk_rx & ~btn_q);
    end

    // Parser, timebase and blanking registers.
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            pre_q    <= '0;
            cnt_q    <= '0;
            btn_q    <= 1'b0;
            enable_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            btn_q    <= btn_d;
            enable_q <= enable_d;
        end
    end

    assign cmd_err = err_q;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .clk     (clk_rx),
            .rst     (rst_clk_rx),
            .wr_en   (wr_all | (wr_one & (ch_q == 8'(i)))),
            .wr_duty (rx_data[7 -: PWM_BITS]),
            .pwm_cnt (cnt_q),
            .enable  (enable_q),
            .led     (led_o[i])
        );
    end

endmodule

// File: tb/tb_uart_led_pwm.sv
// Scoreboard bench: stimulus queues expected LED windows and cmd_err cycles,
// a negedge monitor consumes them as the DUT runs.
module tb_uart_led_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic [7:0] led_o;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_s = 0;

    typedef struct {
        int         at;
        int         len;
        logic [7:0] mask;
        logic [7:0] val;
        int         exp_cnt;
        int         cnt;
        string      name;
    } win_t;

    win_t wq[$];
    int   err_q[$];

    uart_led_pwm #(
        .NUM_LEDS(8), .PWM_BITS(8), .PRESCALE(1), .TIMEOUT_CYC(64)
    ) dut (
        .clk_rx      (clk),
        .rst_clk_rx  (rst),
        .btn_clk_rx  (btn),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_rdy),
        .led_o       (led_o),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count matching cycles in each window, match cmd_err pulses to expected cycles.
    always @(negedge clk) begin
        for (int i = 0; i < wq.size(); i++) begin
            if (cyc >= wq[i].at && cyc < wq[i].at + wq[i].len) begin
                win_t w;
                w = wq[i];
                if ((led_o & w.mask) == w.val) w.cnt++;
                wq[i] = w;
            end
        end
        for (int i = wq.size() - 1; i >= 0; i--) begin
            if (cyc >= wq[i].at + wq[i].len - 1) begin
                checks++;
                if (wq[i].cnt != wq[i].exp_cnt) begin
                    errors++;
                    $display("FAIL %s: matching cycles %0d, required %0d", wq[i].name, wq[i].cnt, wq[i].exp_cnt);
                end
                wq.delete(i);
            end
        end
        if (cmd_err === 1'b1) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_err_unexpected: pulse at cycle %0d, none required", cyc);
            end else begin
                int e;
                e = err_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL cmd_err_cycle: pulse at cycle %0d, required %0d", cyc, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        last_s  = cyc;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic win(input int at, input int len, input logic [7:0] mask,
                       input logic [7:0] val, input int exp_cnt, input string name);
        win_t w;
        w.at = at; w.len = len; w.mask = mask; w.val = val;
        w.exp_cnt = exp_cnt; w.cnt = 0; w.name = name;
        wq.push_back(w);
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    initial begin
        int b;
        // Reset state
        wait_cyc(3);
        chk("reset_outputs", {cmd_err, led_o}, 9'h000);
        rst = 1'b0;
        win(cyc + 1, 10, 8'hFF, 8'h00, 10, "idle_after_reset");
        wait_cyc(12);

        // Single channel at half duty
        send(8'h4C); send(8'h03); send(8'h80);
        win(last_s + 2, 256, 8'h08, 8'h08, 128, "ch3_half_duty");
        win(last_s + 2, 256, 8'hF7, 8'h00, 256, "ch3_others_off");
        wait_cyc(262);

        // All full on, then all off, checking the 2-cycle latency edge
        send(8'h41); send(8'hFF);
        win(last_s + 2, 20, 8'hFF, 8'hFF, 20, "all_on");
        wait_cyc(24);
        send(8'h41); send(8'h00);
        win(last_s + 1, 1, 8'hFF, 8'hFF, 1, "all_off_latency_old");
        win(last_s + 2, 20, 8'hFF, 8'h00, 20, "all_off");
        wait_cyc(24);

        // Out-of-range channel, then whitespace tolerated and channel 0 full on
        send(8'h4C); send(8'h09); send(8'h40);
        err_q.push_back(last_s + 1);
        win(last_s + 2, 10, 8'hFF, 8'h00, 10, "bad_ch_no_write");
        wait_cyc(12);
        send(8'h0D); send(8'h0A); send(8'h4C); send(8'h00); send(8'hFF);
        win(last_s + 2, 20, 8'h01, 8'h01, 20, "ch0_on");
        win(last_s + 2, 20, 8'hFE, 8'h00, 20, "ch0_others_off");
        wait_cyc(24);

        // Truncated command times out; next command accepted
        send(8'h4C); send(8'h02);
        err_q.push_back(last_s + 65);
        win(last_s + 2, 60, 8'hFF, 8'h01, 60, "timeout_no_write");
        wait_cyc(70);
        send(8'h41); send(8'h10);
        win(last_s + 2, 256, 8'hFF, 8'hFF, 16, "all_0x10_on");
        win(last_s + 2, 256, 8'hFF, 8'h00, 240, "all_0x10_off");
        wait_cyc(260);

        // Blanking toggle with channel 1 at half duty
        send(8'h41); send(8'h00);
        send(8'h4C); send(8'h01); send(8'h80);
        wait_cyc(10);
        btn = 1'b1;
        b = cyc;
        win(b + 2, 40, 8'hFF, 8'h00, 40, "blanked");
        wait_cyc(5);
        btn = 1'b0;
        wait_cyc(40);
        btn = 1'b1;
        b = cyc;
        win(b + 2, 256, 8'h02, 8'h02, 128, "unblank_ch1_half");
        win(b + 2, 256, 8'hFD, 8'h00, 256, "unblank_others_off");
        wait_cyc(3);
        btn = 1'b0;
        wait_cyc(260);

        // Reset in GET_DUTY clears outputs asynchronously
        send(8'h41); send(8'hFF);
        win(last_s + 2, 10, 8'hFF, 8'hFF, 10, "pre_reset_all_on");
        wait_cyc(14);
        send(8'h4C); send(8'h05);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {cmd_err, led_o}, 9'h000);
        wait_cyc(3);
        rst = 1'b0;
        win(cyc + 1, 20, 8'hFF, 8'h00, 20, "duties_cleared");
        wait_cyc(22);
        send(8'h4C); send(8'h05); send(8'hC0);
        win(last_s + 2, 256, 8'h20, 8'h20, 192, "post_reset_ch5");
        win(last_s + 2, 256, 8'hDF, 8'h00, 256, "post_reset_others_off");
        wait_cyc(258);

        // Drain
        for (int i = 0; i < 1000 && wq.size() != 0; i++) @(negedge clk);
        checks++;
        if (wq.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending windows %0d cmd_err %0d, required 0 and 0", wq.size(), err_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_led_pwm.md
# uart_led_pwm

Parametrised successor to the fixed 8-bit UART-to-LED controller. The block consumes received bytes (`rx_data`/`rx_data_rdy` from `uart_rx`) and parses a small command protocol that sets per-channel PWM brightness on `NUM_LEDS` outputs. A synchronized button toggles global output blanking, and an inter-byte timeout recovers from truncated commands. It replaces `led_ctl` between `uart_rx` and the LED pins.

## Interface
- `NUM_LEDS`, 8, number of LED channels (1..256)
- `PWM_BITS`, 8, PWM resolution (1..8); the duty byte's upper `PWM_BITS` bits are used
- `PRESCALE`, 1, clock cycles per PWM counter increment (>=1)
- `TIMEOUT_CYC`, 100_000, idle cycles inside a command before abort (>=2)
- `clk_rx` input 1: single clock for the block
- `rst_clk_rx` input 1: reset, asynchronous and active-high
- `btn_clk_rx` input 1: button, already synchronized to `clk_rx`
- `rx_data` input 8: received byte
- `rx_data_rdy` input 1: one-cycle strobe, `rx_data` valid
- `led_o` output `NUM_LEDS`: PWM outputs, registered
- `cmd_err` output 1: one-cycle pulse on a rejected or aborted command

## Operation
- Commands:
  - `0x4C` ('L'), channel, duty: set one channel.
  - `0x41` ('A'), duty: set all channels.
- FSM states: IDLE, GET_CH, GET_DUTY, GET_ALL. All transitions occur only on `rx_data_rdy` or on timeout.
- IDLE:
  - 'L' goes to GET_CH; 'A' goes to GET_ALL.
  - Any other byte is ignored, stays in IDLE, and raises no error (whitespace/CR tolerated).
- GET_CH: latch the byte as a binary channel index, then go to GET_DUTY.
- GET_DUTY:
  - Index < `NUM_LEDS`: write `duty[idx] <= rx_data[7 -: PWM_BITS]`.
  - Otherwise: no write and pulse `cmd_err`.
  - Both cases return to IDLE.
- GET_ALL: write every `duty[i]`, then return to IDLE.
- Timeout:
  - The counter clears on every `rx_data_rdy` and whenever the FSM is in IDLE.
  - In a non-IDLE state, reaching `TIMEOUT_CYC-1` returns the FSM to IDLE and pulses `cmd_err`. The partial command is discarded.
- If `rx_data_rdy` and timeout expiry coincide, the byte wins: it is processed normally and no error is raised.
- PWM:
  - Free-running counter `pwm_cnt` (`PWM_BITS` wide) increments once every `PRESCALE` cycles and wraps from all-ones to 0.
  - Channel on when `duty == all-ones` OR `pwm_cnt < duty`. Duty 0 is always off; duty all-ones is always on.
- Blanking:
  - A rising edge of `btn_clk_rx` (registered previous value, detected in a single cycle) toggles `enable`.
  - When `enable` = 0, `led_o` = 0. Duty registers and the FSM continue unaffected.

## Timing
- Reset values:
  - `led_o` = 0, `cmd_err` = 0, all `duty` = 0, `enable` = 1.
  - FSM in IDLE; `pwm_cnt`, prescaler and timeout counter = 0; button edge register = 0.
- Duty write takes effect on the clock edge ending the final-byte `rx_data_rdy` cycle.
- `led_o` is registered: it reflects the new duty/`pwm_cnt` compare one cycle after the duty update, giving 2 cycles total from strobe to pin.
- `cmd_err` asserts the cycle after the offending strobe or the timeout expiry, for exactly one cycle.
- Button edge: `led_o` blanks or unblanks 2 cycles after `btn_clk_rx` rises.
- Reset asserted mid-command or mid-PWM-period: everything returns to reset values immediately (asynchronously). There is no partial write.
- Back-to-back `rx_data_rdy` on consecutive cycles must be handled, one byte per cycle.

## Structure
- Shared package `uart_led_pkg`:
  - Command constants `CMD_SET_ONE` = 8'h4C and `CMD_SET_ALL` = 8'h41.
  - FSM state enumeration.
- Sub-module `pwm_chan` (one per channel via generate): duty register compare plus registered output. The counter, prescaler and `enable` stay in the parent and are shared.
- Top `uart_led` is updated to instantiate `uart_led_pwm` in place of `led_ctl` and to pass `NUM_LEDS` through to `led_pins`.

## Test plan
- Config for all scenarios: `NUM_LEDS`=8, `PWM_BITS`=8, `PRESCALE`=1, `TIMEOUT_CYC`=64.
- Bytes 4C 03 80 -> `led_o[3]` high for 128 of every 256 cycles; other bits stay 0; no `cmd_err`.
- Bytes 41 FF, then 41 00 -> all LEDs constantly 1, then constantly 0, each starting 2 cycles after the final strobe.
- Bytes 4C 09 40 -> no duty change and one `cmd_err` pulse. Then 0D 0A 4C 00 FF -> `led_o[0]` constantly on, no further error.
- Bytes 4C 02, then 64 idle cycles -> `cmd_err` pulse and FSM back in IDLE. A following 41 10 sets all duties to 0x10.
- With duty 0x80 on channel 1: button rising edge -> `led_o` all 0 two cycles later; second edge -> PWM resumes with duty intact.
- Assert reset during GET_DUTY -> `led_o`=0 and duties 0 asynchronously; a new full command after release is accepted.
